// File: rtl/rv_csr_machine_trap.sv
// rtl/rv_csr_machine_trap.sv - machine CSRs, counters, interrupt arbitration and trap redirect
// Optional CSR_MTVAL_EN: writable mtval captured on traps; when undefined mtval reads 0.
module rv_csr_machine_trap #(
   parameter int EXTENSION_C   = 1,
   parameter int CNT_WIDTH     = 64,
   parameter int VECTORED_EN_P = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_sel,
   input  logic        i_cnt_sel,
   input  logic [7:0]  i_idx,
   input  logic [31:0] i_data,
   input  logic        i_write,
   input  logic        i_set,
   input  logic        i_clear,
   input  logic [30:0] i_pc,
   input  logic        i_exc_valid,
   input  logic [4:0]  i_exc_code,
   input  logic [31:0] i_exc_tval,
   input  logic        i_irq_accept,
   input  logic        i_irq_ext,
   input  logic        i_irq_timer,
   input  logic        i_irq_soft,
   input  logic        i_mret,
   input  logic        i_instret,
   output logic [31:0] o_data,
   output logic        o_trap_valid,
   output logic [30:0] o_trap_pc,
   output logic        o_irq_pending,
   output logic        o_mie
);
   typedef enum logic {S_IDLE = 1'b0, S_REDIRECT = 1'b1} state_t;

   localparam logic [31:0] MEPC_MASK = (EXTENSION_C != 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
   localparam logic [31:0] MISA_VAL  = (EXTENSION_C != 0) ? 32'h4000_0104 : 32'h4000_0100;

   state_t                 state_q, state_d;
   logic [30:0]            trap_pc_q, trap_pc_d;
   logic                   mst_mie_q, mst_mie_d;
   logic                   mst_mpie_q, mst_mpie_d;
   logic [2:0]             mie_q, mie_d;
   logic [29:0]            tvec_base_q, tvec_base_d;
   logic [1:0]             tvec_mode_q, tvec_mode_d;
   logic [1:0]             inhibit_q, inhibit_d;
   logic [31:0]            mscratch_q, mscratch_d;
   logic [31:0]            mepc_q, mepc_d;
   logic [31:0]            mcause_q, mcause_d;
   logic [CNT_WIDTH-1:0]   mcycle_q, mcycle_d;
   logic [CNT_WIDTH-1:0]   minstret_q, minstret_d;
`ifdef CSR_MTVAL_EN
   logic [31:0]            mtval_q, mtval_d;
`else
   logic                   unused_tval;
   assign unused_tval = ^i_exc_tval;
`endif

   logic [63:0] mcycle_full, minstret_full, mcycle_nx, minstret_nx;
   logic [31:0] rdata, wval, mtval_rd;
   logic        wr_en, csr_wr, cnt_wr;
   logic [2:0]  pend;
   logic [4:0]  irq_code, cause_code;
   logic        take_exc, take_irq, take_mret, take_trap;
   logic [30:0] trap_target;

   // Counters are handled as 64-bit values; a 32-bit build zero-extends, so its
   // high halves read 0 and high writes fall away on truncation.
   assign mcycle_full   = 64'(mcycle_q);
   assign minstret_full = 64'(minstret_q);

`ifdef CSR_MTVAL_EN
   assign mtval_rd = mtval_q;
`else
   assign mtval_rd = 32'h0;
`endif

   always_comb begin
      rdata = 32'h0;
      if (i_sel) begin
         case (i_idx)
            8'h00: rdata = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            8'h01: rdata = MISA_VAL;
            8'h04: rdata = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
            8'h05: rdata = {tvec_base_q, tvec_mode_q};
            8'h20: rdata = {29'b0, inhibit_q[1], 1'b0, inhibit_q[0]};
            8'h40: rdata = mscratch_q;
            8'h41: rdata = mepc_q;
            8'h42: rdata = mcause_q;
            8'h43: rdata = mtval_rd;
            8'h44: rdata = {20'b0, i_irq_ext, 3'b0, i_irq_timer, 3'b0, i_irq_soft, 3'b0};
            default: rdata = 32'h0;
         endcase
      end else if (i_cnt_sel) begin
         case (i_idx)
            8'h00: rdata = mcycle_full[31:0];
            8'h02: rdata = minstret_full[31:0];
            8'h80: rdata = mcycle_full[63:32];
            8'h82: rdata = minstret_full[63:32];
            default: rdata = 32'h0;
         endcase
      end
   end

   assign o_data = rdata;
   assign wr_en  = i_write | i_set | i_clear;
   assign csr_wr = i_sel & wr_en;
   assign cnt_wr = i_cnt_sel & wr_en;
   assign wval   = i_write ? i_data : (i_set ? (rdata | i_data) : (rdata & ~i_data));

   // pend order is {ext, timer, soft}; soft outranks timer
   assign pend          = {i_irq_ext, i_irq_timer, i_irq_soft} & mie_q & {3{mst_mie_q}};
   assign o_irq_pending = |pend;
   assign irq_code      = pend[2] ? 5'd11 : (pend[0] ? 5'd3 : 5'd7);

   assign take_exc   = (state_q == S_IDLE) & i_exc_valid;
   assign take_irq   = (state_q == S_IDLE) & ~i_exc_valid & o_irq_pending & i_irq_accept;
   assign take_mret  = (state_q == S_IDLE) & ~i_exc_valid & ~(o_irq_pending & i_irq_accept) & i_mret;
   assign take_trap  = take_exc | take_irq;
   assign cause_code = take_exc ? i_exc_code : irq_code;
   // Target computed in halfword units: base/2 + 2*code
   assign trap_target = (take_irq && tvec_mode_q == 2'b01)
                      ? ({tvec_base_q, 1'b0} + {25'b0, cause_code, 1'b0})
                      : {tvec_base_q, 1'b0};

   always_comb begin
      state_d     = state_q;
      trap_pc_d   = trap_pc_q;
      mst_mie_d   = mst_mie_q;
      mst_mpie_d  = mst_mpie_q;
      mie_d       = mie_q;
      tvec_base_d = tvec_base_q;
      tvec_mode_d = tvec_mode_q;
      inhibit_d   = inhibit_q;
      mscratch_d  = mscratch_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;
`ifdef CSR_MTVAL_EN
      mtval_d     = mtval_q;
`endif
      if (csr_wr) begin
         case (i_idx)
            8'h00: begin
               mst_mie_d  = wval[3];
               mst_mpie_d = wval[7];
            end
            8'h04: mie_d = {wval[11], wval[7], wval[3]};
            8'h05: begin
               tvec_base_d = wval[31:2];
               tvec_mode_d = (wval[1:0] == 2'b01 && VECTORED_EN_P != 0) ? 2'b01 : 2'b00;
            end
            8'h20: inhibit_d  = {wval[2], wval[0]};
            8'h40: mscratch_d = wval;
            8'h41: mepc_d     = wval & MEPC_MASK;
            8'h42: mcause_d   = wval;
`ifdef CSR_MTVAL_EN
            8'h43: mtval_d    = wval;
`endif
            default: ;
         endcase
      end

      case (state_q)
         S_IDLE:     if (take_trap || take_mret) state_d = S_REDIRECT;
         S_REDIRECT: state_d = S_IDLE;
      endcase

      // Trap side effects come last so they override a same-cycle CSR write
      if (take_trap) begin
         mepc_d     = {i_pc, 1'b0} & MEPC_MASK;
         mcause_d   = {take_irq, 26'b0, cause_code};
         mst_mpie_d = mst_mie_q;
         mst_mie_d  = 1'b0;
         trap_pc_d  = trap_target;
`ifdef CSR_MTVAL_EN
         mtval_d    = take_exc ? i_exc_tval : 32'h0;
`endif
      end else if (take_mret) begin
         mst_mie_d  = mst_mpie_q;
         mst_mpie_d = 1'b1;
         trap_pc_d  = mepc_q[31:1];
      end
   end

   always_comb begin
      mcycle_nx = mcycle_full;
      if (cnt_wr && i_idx == 8'h00)      mcycle_nx = {mcycle_full[63:32], wval};
      else if (cnt_wr && i_idx == 8'h80) mcycle_nx = {wval, mcycle_full[31:0]};
      else if (!inhibit_q[0])            mcycle_nx = mcycle_full + 64'd1;
      minstret_nx = minstret_full;
      if (cnt_wr && i_idx == 8'h02)        minstret_nx = {minstret_full[63:32], wval};
      else if (cnt_wr && i_idx == 8'h82)   minstret_nx = {wval, minstret_full[31:0]};
      else if (i_instret && !inhibit_q[1]) minstret_nx = minstret_full + 64'd1;
      mcycle_d   = mcycle_nx[CNT_WIDTH-1:0];
      minstret_d = minstret_nx[CNT_WIDTH-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         trap_pc_q   <= '0;
         mst_mie_q   <= 1'b0;
         mst_mpie_q  <= 1'b0;
         mie_q       <= '0;
         tvec_base_q <= '0;
         tvec_mode_q <= '0;
         inhibit_q   <= '0;
         mscratch_q  <= '0;
         mepc_q      <= '0;
         mcause_q    <= '0;
         mcycle_q    <= '0;
         minstret_q  <= '0;
`ifdef CSR_MTVAL_EN
         mtval_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         trap_pc_q   <= trap_pc_d;
         mst_mie_q   <= mst_mie_d;
         mst_mpie_q  <= mst_mpie_d;
         mie_q       <= mie_d;
         tvec_base_q <= tvec_base_d;
         tvec_mode_q <= tvec_mode_d;
         inhibit_q   <= inhibit_d;
         mscratch_q  <= mscratch_d;
         mepc_q      <= mepc_d;
         mcause_q    <= mcause_d;
         mcycle_q    <= mcycle_d;
         minstret_q  <= minstret_d;
`ifdef CSR_MTVAL_EN
         mtval_q     <= mtval_d;
`endif
      end
   end

   assign o_trap_valid = (state_q == S_REDIRECT);
   assign o_trap_pc    = trap_pc_q;
   assign o_mie        = mst_mie_q;
endmodule

// File: tb/tb_rv_csr_machine_trap.sv
// tb/tb_rv_csr_machine_trap.sv - directed bench for rv_csr_machine_trap
// dut0 uses default parameters; dut1 shares stimulus with EXTENSION_C=0, CNT_WIDTH=32, VECTORED_EN_P=0.
module tb_rv_csr_machine_trap;
   logic        clk = 1'b0, rst = 1'b1;
   logic        sel = 1'b0, cnt_sel = 1'b0, wr = 1'b0, set = 1'b0, clr = 1'b0;
   logic [7:0]  idx = 8'h0;
   logic [31:0] data = 32'h0, exc_tval = 32'h0;
   logic [30:0] pc = 31'h0;
   logic        exc_valid = 1'b0, irq_accept = 1'b0, mret = 1'b0, instret = 1'b0;
   logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_soft = 1'b0;
   logic [4:0]  exc_code = 5'h0;
   logic [31:0] data0, data1;
   logic        tv0, tv1, pend0, pend1, mie0, mie1;
   logic [30:0] tpc0, tpc1;
   logic [31:0] r0, r1;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   rv_csr_machine_trap dut0 (
      .i_clk(clk), .i_reset(rst), .i_sel(sel), .i_cnt_sel(cnt_sel), .i_idx(idx), .i_data(data),
      .i_write(wr), .i_set(set), .i_clear(clr), .i_pc(pc), .i_exc_valid(exc_valid),
      .i_exc_code(exc_code), .i_exc_tval(exc_tval), .i_irq_accept(irq_accept),
      .i_irq_ext(irq_ext), .i_irq_timer(irq_timer), .i_irq_soft(irq_soft), .i_mret(mret),
      .i_instret(instret), .o_data(data0), .o_trap_valid(tv0), .o_trap_pc(tpc0),
      .o_irq_pending(pend0), .o_mie(mie0));

   rv_csr_machine_trap #(.EXTENSION_C(0), .CNT_WIDTH(32), .VECTORED_EN_P(0)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_sel(sel), .i_cnt_sel(cnt_sel), .i_idx(idx), .i_data(data),
      .i_write(wr), .i_set(set), .i_clear(clr), .i_pc(pc), .i_exc_valid(exc_valid),
      .i_exc_code(exc_code), .i_exc_tval(exc_tval), .i_irq_accept(irq_accept),
      .i_irq_ext(irq_ext), .i_irq_timer(irq_timer), .i_irq_soft(irq_soft), .i_mret(mret),
      .i_instret(instret), .o_data(data1), .o_trap_valid(tv1), .o_trap_pc(tpc1),
      .o_irq_pending(pend1), .o_mie(mie1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // op: 0 write, 1 set, 2 clear; cs selects the counter space
   task automatic csr_op(input logic cs, input logic [7:0] a, input logic [31:0] v, input int op);
      sel = ~cs; cnt_sel = cs; idx = a; data = v;
      wr = (op == 0); set = (op == 1); clr = (op == 2);
      tick();
      sel = 1'b0; cnt_sel = 1'b0; wr = 1'b0; set = 1'b0; clr = 1'b0;
   endtask

   task automatic csr_rd(input logic cs, input logic [7:0] a, output logic [31:0] v0, output logic [31:0] v1);
      sel = ~cs; cnt_sel = cs; idx = a;
      #1;
      v0 = data0; v1 = data1;
      sel = 1'b0; cnt_sel = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick();
      checks++; if (tv0 !== 1'b0) begin $display("FAIL reset_trap_valid got=%b exp=0", tv0); failures++; end
      checks++; if (tpc0 !== 31'h0) begin $display("FAIL reset_trap_pc got=%h exp=0", tpc0); failures++; end
      checks++; if (mie0 !== 1'b0) begin $display("FAIL reset_mie got=%b exp=0", mie0); failures++; end
      csr_rd(1'b0, 8'h00, r0, r1);
      checks++; if (r0 !== 32'h0000_1800) begin $display("FAIL reset_mstatus got=%h exp=00001800", r0); failures++; end
      csr_rd(1'b0, 8'h01, r0, r1);
      checks++; if (r0 !== 32'h4000_0104) begin $display("FAIL misa_c1 got=%h exp=40000104", r0); failures++; end
      checks++; if (r1 !== 32'h4000_0100) begin $display("FAIL misa_c0 got=%h exp=40000100", r1); failures++; end
      csr_rd(1'b1, 8'h00, r0, r1);
      checks++; if (r0 !== 32'h0) begin $display("FAIL reset_mcycle got=%h exp=0", r0); failures++; end
      rst = 1'b0;
   endtask

   task automatic test_counter_wrap();
      csr_op(1'b1, 8'h00, 32'hFFFF_FFFF, 0);
      csr_op(1'b1, 8'h80, 32'h0, 0);
      csr_rd(1'b1, 8'h00, r0, r1);
      checks++; if (r0 !== 32'hFFFF_FFFF) begin $display("FAIL wrap_hold_low got=%h exp=ffffffff", r0); failures++; end
      tick();
      csr_rd(1'b1, 8'h00, r0, r1);
      checks++; if (r0 !== 32'h0) begin $display("FAIL wrap_low64 got=%h exp=0", r0); failures++; end
      checks++; if (r1 !== 32'h0) begin $display("FAIL wrap_low32 got=%h exp=0", r1); failures++; end
      tick();
      csr_rd(1'b1, 8'h80, r0, r1);
      checks++; if (r0 !== 32'h1) begin $display("FAIL wrap_high64 got=%h exp=1", r0); failures++; end
      checks++; if (r1 !== 32'h0) begin $display("FAIL wrap_high32 got=%h exp=0", r1); failures++; end
   endtask

   task automatic test_inhibit();
      csr_op(1'b0, 8'h20, 32'h1, 0);
      csr_op(1'b1, 8'h00, 32'h5, 0);
      tick(); tick();
      csr_rd(1'b1, 8'h00, r0, r1);
      checks++; if (r0 !== 32'h5) begin $display("FAIL inhibit_mcycle got=%h exp=5", r0); failures++; end
      csr_op(1'b1, 8'h02, 32'h0, 0);
      instret = 1'b1; tick(); tick(); tick(); instret = 1'b0;
      csr_rd(1'b1, 8'h02, r0, r1);
      checks++; if (r0 !== 32'h3) begin $display("FAIL minstret_count got=%h exp=3", r0); failures++; end
      csr_op(1'b0, 8'h20, 32'h4, 0);
      instret = 1'b1; tick(); tick(); instret = 1'b0;
      csr_rd(1'b1, 8'h02, r0, r1);
      checks++; if (r0 !== 32'h3) begin $display("FAIL inhibit_minstret got=%h exp=3", r0); failures++; end
      csr_op(1'b0, 8'h20, 32'h0, 0);
   endtask

   task automatic test_modify();
      csr_op(1'b0, 8'h40, 32'h0F0F_0000, 0);
      csr_op(1'b0, 8'h40, 32'h0000_00FF, 1);
      csr_rd(1'b0, 8'h40, r0, r1);
      checks++; if (r0 !== 32'h0F0F_00FF) begin $display("FAIL set_mscratch got=%h exp=0f0f00ff", r0); failures++; end
      csr_op(1'b0, 8'h40, 32'h0F00_0000, 2);
      csr_rd(1'b0, 8'h40, r0, r1);
      checks++; if (r0 !== 32'h000F_00FF) begin $display("FAIL clear_mscratch got=%h exp=000f00ff", r0); failures++; end
   endtask

   task automatic test_warl();
      csr_op(1'b0, 8'h05, 32'h0000_1003, 0);
      csr_rd(1'b0, 8'h05, r0, r1);
      checks++; if (r0 !== 32'h0000_1000) begin $display("FAIL mtvec_mode3 got=%h exp=00001000", r0); failures++; end
      csr_op(1'b0, 8'h05, 32'h8000_0101, 0);
      csr_rd(1'b0, 8'h05, r0, r1);
      checks++; if (r0 !== 32'h8000_0101) begin $display("FAIL mtvec_vec got=%h exp=80000101", r0); failures++; end
      checks++; if (r1 !== 32'h8000_0100) begin $display("FAIL mtvec_novec got=%h exp=80000100", r1); failures++; end
      csr_op(1'b0, 8'h41, 32'h0000_0203, 0);
      csr_rd(1'b0, 8'h41, r0, r1);
      checks++; if (r0 !== 32'h0000_0202) begin $display("FAIL mepc_c1 got=%h exp=00000202", r0); failures++; end
      checks++; if (r1 !== 32'h0000_0200) begin $display("FAIL mepc_c0 got=%h exp=00000200", r1); failures++; end
   endtask

   task automatic test_exception();
      csr_op(1'b0, 8'h00, 32'h8, 0);
      checks++; if (mie0 !== 1'b1) begin $display("FAIL mie_set got=%b exp=1", mie0); failures++; end
      pc = 31'h80; exc_code = 5'd2; exc_tval = 32'hDEAD_BEEF; exc_valid = 1'b1;
      #1;
      checks++; if (tv0 !== 1'b0) begin $display("FAIL exc_early_valid got=%b exp=0", tv0); failures++; end
      tick(); exc_valid = 1'b0;
      checks++; if (tv0 !== 1'b1) begin $display("FAIL exc_valid got=%b exp=1", tv0); failures++; end
      checks++; if ({tpc0, 1'b0} !== 32'h8000_0100) begin $display("FAIL exc_pc got=%h exp=80000100", {tpc0, 1'b0}); failures++; end
      checks++; if (mie0 !== 1'b0) begin $display("FAIL exc_mie got=%b exp=0", mie0); failures++; end
      tick();
      checks++; if (tv0 !== 1'b0) begin $display("FAIL exc_one_cycle got=%b exp=0", tv0); failures++; end
      csr_rd(1'b0, 8'h41, r0, r1);
      checks++; if (r0 !== 32'h100) begin $display("FAIL exc_mepc got=%h exp=00000100", r0); failures++; end
      csr_rd(1'b0, 8'h42, r0, r1);
      checks++; if (r0 !== 32'h2) begin $display("FAIL exc_mcause got=%h exp=2", r0); failures++; end
      csr_rd(1'b0, 8'h00, r0, r1);
      checks++; if (r0 !== 32'h0000_1880) begin $display("FAIL exc_mstatus got=%h exp=00001880", r0); failures++; end
      csr_rd(1'b0, 8'h43, r0, r1);
`ifdef CSR_MTVAL_EN
      checks++; if (r0 !== 32'hDEAD_BEEF) begin $display("FAIL exc_mtval got=%h exp=deadbeef", r0); failures++; end
`else
      checks++; if (r0 !== 32'h0) begin $display("FAIL exc_mtval got=%h exp=0", r0); failures++; end
`endif
   endtask

   task automatic test_vectored_irq();
      csr_op(1'b0, 8'h00, 32'h8, 0);
      csr_op(1'b0, 8'h04, 32'h80, 0);
      irq_timer = 1'b1; pc = 31'h90;
      #1;
      checks++; if (pend0 !== 1'b1) begin $display("FAIL irq_pending got=%b exp=1", pend0); failures++; end
      irq_accept = 1'b1;
      tick(); irq_accept = 1'b0; irq_timer = 1'b0;
      checks++; if ({tpc0, 1'b0} !== 32'h8000_011C) begin $display("FAIL vec_pc got=%h exp=8000011c", {tpc0, 1'b0}); failures++; end
      checks++; if ({tpc1, 1'b0} !== 32'h8000_0100) begin $display("FAIL novec_pc got=%h exp=80000100", {tpc1, 1'b0}); failures++; end
      tick();
      csr_rd(1'b0, 8'h42, r0, r1);
      checks++; if (r0 !== 32'h8000_0007) begin $display("FAIL timer_mcause got=%h exp=80000007", r0); failures++; end
   endtask

   task automatic test_priority();
      csr_op(1'b0, 8'h00, 32'h8, 0);
      csr_op(1'b0, 8'h04, 32'h888, 0);
      irq_ext = 1'b1; irq_soft = 1'b1; irq_timer = 1'b1; irq_accept = 1'b1;
      tick(); irq_accept = 1'b0;
      checks++; if ({tpc0, 1'b0} !== 32'h8000_012C) begin $display("FAIL ext_pc got=%h exp=8000012c", {tpc0, 1'b0}); failures++; end
      tick();
      csr_rd(1'b0, 8'h42, r0, r1);
      checks++; if (r0 !== 32'h8000_000B) begin $display("FAIL ext_mcause got=%h exp=8000000b", r0); failures++; end
      irq_ext = 1'b0;
      csr_op(1'b0, 8'h00, 32'h8, 0);
      irq_accept = 1'b1;
      tick(); irq_accept = 1'b0;
      checks++; if ({tpc0, 1'b0} !== 32'h8000_010C) begin $display("FAIL soft_pc got=%h exp=8000010c", {tpc0, 1'b0}); failures++; end
      tick();
      irq_ext = 1'b1;
      csr_op(1'b0, 8'h00, 32'h8, 0);
      irq_accept = 1'b1; exc_valid = 1'b1; exc_code = 5'd5;
      tick(); irq_accept = 1'b0; exc_valid = 1'b0;
      irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
      checks++; if ({tpc0, 1'b0} !== 32'h8000_0100) begin $display("FAIL excwin_pc got=%h exp=80000100", {tpc0, 1'b0}); failures++; end
      tick();
      csr_rd(1'b0, 8'h42, r0, r1);
      checks++; if (r0 !== 32'h5) begin $display("FAIL excwin_mcause got=%h exp=5", r0); failures++; end
   endtask

   task automatic test_mret();
      csr_op(1'b0, 8'h41, 32'h200, 0);
      csr_op(1'b0, 8'h00, 32'h80, 0);
      mret = 1'b1; sel = 1'b1; idx = 8'h00; data = 32'h0; wr = 1'b1;
      tick(); mret = 1'b0; sel = 1'b0; wr = 1'b0;
      checks++; if (tv0 !== 1'b1) begin $display("FAIL mret_valid got=%b exp=1", tv0); failures++; end
      checks++; if ({tpc0, 1'b0} !== 32'h200) begin $display("FAIL mret_pc got=%h exp=00000200", {tpc0, 1'b0}); failures++; end
      checks++; if (mie0 !== 1'b1) begin $display("FAIL mret_mie got=%b exp=1", mie0); failures++; end
      tick();
      csr_rd(1'b0, 8'h00, r0, r1);
      checks++; if (r0 !== 32'h0000_1888) begin $display("FAIL mret_mstatus got=%h exp=00001888", r0); failures++; end
   endtask

   task automatic test_back_to_back();
      exc_valid = 1'b1; exc_code = 5'd4; pc = 31'h40;
      tick();
      exc_code = 5'd6; pc = 31'h60;
      checks++; if (tv0 !== 1'b1) begin $display("FAIL b2b_first got=%b exp=1", tv0); failures++; end
      tick(); exc_valid = 1'b0;
      checks++; if (tv0 !== 1'b0) begin $display("FAIL b2b_ignored got=%b exp=0", tv0); failures++; end
      tick();
      checks++; if (tv0 !== 1'b0) begin $display("FAIL b2b_idle got=%b exp=0", tv0); failures++; end
      csr_rd(1'b0, 8'h42, r0, r1);
      checks++; if (r0 !== 32'h4) begin $display("FAIL b2b_mcause got=%h exp=4", r0); failures++; end
      csr_rd(1'b0, 8'h41, r0, r1);
      checks++; if (r0 !== 32'h80) begin $display("FAIL b2b_mepc got=%h exp=00000080", r0); failures++; end
   endtask

   task automatic test_reset_in_redirect();
      exc_valid = 1'b1; exc_code = 5'd2;
      tick(); exc_valid = 1'b0; rst = 1'b1;
      checks++; if (tv0 !== 1'b1) begin $display("FAIL rr_pre got=%b exp=1", tv0); failures++; end
      tick(); rst = 1'b0;
      checks++; if (tv0 !== 1'b0) begin $display("FAIL rr_valid got=%b exp=0", tv0); failures++; end
      checks++; if (tpc0 !== 31'h0) begin $display("FAIL rr_pc got=%h exp=0", tpc0); failures++; end
      tick();
      checks++; if (tv0 !== 1'b0) begin $display("FAIL rr_after got=%b exp=0", tv0); failures++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_counter_wrap();
      test_inhibit();
      test_modify();
      test_warl();
      test_exception();
      test_vectored_irq();
      test_priority();
      test_mret();
      test_back_to_back();
      test_reset_in_redirect();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
